jk_excitation_driver: RTL and testbench

- Drives a bank of WIDTH JK flip-flops from the team's JK_flipflop cell to a requested target state.
- Computes J/K excitation from the current flop outputs fed back on q_fb. Drives J/K for exactly one clock, then checks that the flops reached the target.
- Reports per-lane mismatch and keeps a saturating error count.
- Sits between a target-pattern producer (valid/ready source) and the JK flop bank. It is the control-side counterpart of the flop: it produces J/K, the flop consumes them.

---
 rtl/jk_drv_pkg.sv | 30 +++
 rtl/jk_excite_lane.sv | 19 +
 rtl/jk_excitation_driver.sv | 120 ++++++++++++
 tb/tb_jk_excitation_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_drv_pkg.sv
// Shared types and the per-lane JK excitation function for the JK excitation driver.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StDrive = 2'b01,
    StCheck = 2'b10
  } drv_state_e;

  // {j, k} encodings
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Excitation that moves a JK flop from cur to tgt in one edge.
  function automatic logic [1:0] jk_excite(input logic cur, input logic tgt,
                                           input logic use_toggle);
    logic [1:0] jk;
    if (cur == tgt) begin
      jk = JK_HOLD;
    end else if (use_toggle) begin
      jk = JK_TOGGLE;
    end else begin
      jk = tgt ? JK_SET : JK_RESET;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite_lane.sv
// Combinational J/K excitation for a single flop lane.
module jk_excite_lane
  import jk_drv_pkg::*;
#(
  parameter int unsigned USE_TOGGLE = 0
) (
  input  logic cur_i,
  input  logic tgt_i,
  output logic j_o,
  output logic k_o
);

  logic [1:0] jk;

  assign jk  = jk_excite(cur_i, tgt_i, USE_TOGGLE != 0);
  assign j_o = jk[1];
  assign k_o = jk[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flop bank to a requested pattern for one cycle, then checks the result.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned USE_TOGGLE = 0,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  input  logic             err_clr,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] ErrMax = '1;

  drv_state_e       state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;
  logic [WIDTH-1:0] chk_diff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    jk_excite_lane #(
      .USE_TOGGLE(USE_TOGGLE)
    ) u_lane (
      .cur_i(q_fb[i]),
      .tgt_i(tgt_data[i]),
      .j_o  (exc_j[i]),
      .k_o  (exc_k[i])
    );
  end

  assign chk_diff = q_fb ^ tgt_q;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    j_d        = '0;
    k_d        = '0;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = StDrive;
        end
      end
      StDrive: begin
        state_d = StCheck;
      end
      StCheck: begin
        mismatch_d = chk_diff;
        done_d     = 1'b1;
        if ((chk_diff != '0) && (err_q != ErrMax)) begin
          err_d = err_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Clear takes priority over a coincident failing check.
    if (err_clr) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tgt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      mismatch_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  // Depends only on state and reset, never on tgt_valid.
  assign tgt_ready = (state_q == StIdle) && rst_n;
  assign busy      = (state_q != StIdle);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: three driver configurations, each loading its own 4-lane JK flop model.
module tb_jk_excitation_driver;

  logic       clk;
  logic       rst_n;
  logic       tgt_valid;
  logic [3:0] tgt_data;
  logic       err_clr;
  logic [3:0] stuck;

  logic [3:0] q0, q1, q2;
  logic [3:0] q_fb0, q_fb1, q_fb2;

  logic [3:0] j0, k0, mm0, j1, k1, mm1, j2, k2, mm2;
  logic       rdy0, busy0, done0, rdy1, busy1, done1, rdy2, busy2, done2;
  logic [7:0] err0, err1;
  logic [1:0] err2;

  int n_checks;
  int n_errors;

  // Lanes in stuck read 0 on the feedback path only; the flop itself still moves.
  assign q_fb0 = q0 & ~stuck;
  assign q_fb1 = q1 & ~stuck;
  assign q_fb2 = q2 & ~stuck;

  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(0), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy0), .tgt_data(tgt_data),
    .q_fb(q_fb0), .err_clr(err_clr), .j(j0), .k(k0), .busy(busy0), .done(done0),
    .mismatch(mm0), .err_cnt(err0)
  );

  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy1), .tgt_data(tgt_data),
    .q_fb(q_fb1), .err_clr(err_clr), .j(j1), .k(k1), .busy(busy1), .done(done1),
    .mismatch(mm1), .err_cnt(err1)
  );

  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(0), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy2), .tgt_data(tgt_data),
    .q_fb(q_fb2), .err_clr(err_clr), .j(j2), .k(k2), .busy(busy2), .done(done2),
    .mismatch(mm2), .err_cnt(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] jj,
                                         input logic [3:0] kk);
    return (jj & ~q) | (~kk & q);
  endfunction

  // JK flop bank loads sharing clk/rst_n with the drivers.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else begin
      q0 <= jk_next(q0, j0, k0);
      q1 <= jk_next(q1, j1, k1);
      q2 <= jk_next(q2, j2, k2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE; returns one cycle after the done pulse.
  task automatic send(input logic [3:0] tgt, input logic [3:0] ej0, input logic [3:0] ek0,
                      input logic [3:0] ej1, input logic [3:0] ek1, input logic clr);
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    chk("ready_idle", 32'(rdy0), 32'd1);
    tick();
    tgt_valid = 1'b0;
    chk("drive_j0", 32'(j0), 32'(ej0));
    chk("drive_k0", 32'(k0), 32'(ek0));
    chk("drive_j1", 32'(j1), 32'(ej1));
    chk("drive_k1", 32'(k1), 32'(ek1));
    chk("drive_busy", 32'(busy0), 32'd1);
    chk("drive_ready", 32'(rdy0), 32'd0);
    tick();
    chk("check_jk0", 32'({j0, k0}), 32'd0);
    chk("check_busy", 32'(busy1), 32'd1);
    chk("check_done", 32'(done0), 32'd0);
    if (clr) err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("done_pulse0", 32'(done0), 32'd1);
    chk("done_pulse1", 32'(done1), 32'd1);
    tick();
    chk("done_end", 32'(done0), 32'd0);
    chk("idle_busy", 32'(busy0), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    err_clr   = 1'b0;
    stuck     = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_j", 32'(j0), 32'd0);
    chk("rst_k", 32'(k0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready_after", 32'(rdy0), 32'd1);
    chk("rst_mm", 32'(mm0), 32'd0);

    // Set pattern
    send(4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 1'b0);
    chk("set_q0", 32'(q0), 32'b1010);
    chk("set_q1", 32'(q1), 32'b1010);
    chk("set_mm", 32'(mm0), 32'd0);
    chk("set_err", 32'(err0), 32'd0);

    // Mixed change
    send(4'b0110, 4'b0100, 4'b1000, 4'b1100, 4'b1100, 1'b0);
    chk("mix_q0", 32'(q0), 32'b0110);
    chk("mix_q1", 32'(q1), 32'b0110);
    chk("mix_mm1", 32'(mm1), 32'd0);

    send(4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0110, 1'b0);
    chk("zero_q0", 32'(q0), 32'd0);

    // Fault: lane 2 feedback stuck at 0
    stuck = 4'b0100;
    send(4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    chk("fault_mm", 32'(mm0), 32'b0100);
    chk("fault_err0", 32'(err0), 32'd1);
    chk("fault_err2", 32'(err2), 32'd1);
    stuck = 4'b0000;
    send(4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 1'b0);
    chk("fault_rel_mm", 32'(mm0), 32'd0);
    chk("fault_rel_err", 32'(err0), 32'd1);

    // Saturation and clear
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err0", 32'(err0), 32'd0);
    chk("clr_err2", 32'(err2), 32'd0);
    chk("clr_keeps_mm", 32'(mm0), 32'd0);
    stuck = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      send(4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0);
      chk("sat_err2", 32'(err2), (i < 3) ? 32'(i + 1) : 32'd3);
      chk("sat_err0", 32'(err0), 32'(i + 1));
    end
    send(4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1);
    chk("clr_win_err2", 32'(err2), 32'd0);
    chk("clr_win_err0", 32'(err0), 32'd0);
    chk("clr_win_mm", 32'(mm2), 32'b0100);
    stuck = 4'b0000;

    // Handshake: data changes while busy are ignored
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tgt_valid = 1'b1;
    tgt_data  = 4'b0011;
    tick();
    tgt_data = 4'b1100;
    chk("hs_j", 32'(j0), 32'b0011);
    chk("hs_k", 32'(k0), 32'd0);
    tick();
    tgt_data = 4'b1111;
    chk("hs_ready_chk", 32'(rdy0), 32'd0);
    tick();
    tgt_valid = 1'b0;
    chk("hs_done", 32'(done0), 32'd1);
    chk("hs_mm", 32'(mm0), 32'd0);
    chk("hs_q0", 32'(q0), 32'b0011);
    tick();
    chk("hs_idle_jk", 32'({j0, k0}), 32'd0);
    chk("hs_ready", 32'(rdy0), 32'd1);

    // Reset abort during DRIVE
    tgt_valid = 1'b1;
    tgt_data  = 4'b1111;
    tick();
    tgt_valid = 1'b0;
    chk("ab_drive_j", 32'(j0), 32'b1100);
    rst_n = 1'b0;
    tick();
    chk("ab_jk0", 32'({j0, k0}), 32'd0);
    chk("ab_jk1", 32'({j1, k1}), 32'd0);
    chk("ab_busy", 32'(busy0), 32'd0);
    chk("ab_done", 32'(done0), 32'd0);
    chk("ab_ready_low", 32'(rdy0), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ab_done_after", 32'(done0), 32'd0);
    chk("ab_ready", 32'(rdy0), 32'd1);
    tick();
    chk("ab_done_after2", 32'(done0), 32'd0);
    chk("ab_busy_after", 32'(busy0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
